sesion_cliente: RTL and testbench
=================================

# sesion_cliente

Customer-side session driver for the `cajero_atm` protocol. It is the initiator for the ATM's card, PIN digit and amount strobes. On a start pulse it inserts the card, serializes a 4-digit PIN as `digito`/`digito_stb` pulses, and issues the transaction with `monto_stb`. It then watches the ATM status outputs and reports a single coded result. It sits between a host/test sequencer and `cajero_atm`, replacing hand-written stimulus for the keypad side.

## Interface
Parameters:
- `GAP_CYCLES`, 2, idle cycles between consecutive digit strobes (≥0)
- `PIN_WAIT`, 4, cycles after the last digit strobe spent watching for PIN rejection (≥1)
- `TIMEOUT`, 255, cycles after `monto_stb` to wait for a transaction response (≥1)

Ports:
- `clk` in 1: single clock; all logic on the rising edge
- `reset` in 1: synchronous, active-low
- `inicio` in 1: start pulse; ignored while `ocupado`=1
- `pin_cliente` in 16: four BCD digits; [15:12] is sent first
- `tipo_cliente` in 1: 1 = withdrawal, 0 = deposit
- `monto_cliente` in 32: transaction amount
- `balance_stb`, `entregar_dinero`, `fondos_insuficientes`, `pin_incorrecto`, `advertencia`, `bloqueo` in 1 each: ATM status
- `tarjeta_recibida` out 1: card-present level
- `digito` out 4: PIN digit; 0 when `digito_stb`=0
- `digito_stb` out 1: one-cycle digit strobe
- `tipo_trans` out 1 and `monto` out 32: transaction fields, stable from `monto_stb` until `resultado_stb`
- `monto_stb` out 1: one-cycle amount strobe
- `ocupado` out 1: session in progress
- `resultado` out 3: 0 OK, 1 FONDOS_INSUF, 2 PIN_INC, 3 BLOQUEO, 4 TIMEOUT; held until the next session ends
- `resultado_stb` out 1: one-cycle result-valid pulse
- `aviso` out 1: `advertencia` was seen during the current session; cleared on `inicio` acceptance

## Operation
- Reset (`reset`=0 at an edge): every output is 0 and the FSM goes to IDLE. Reset during a session aborts it: `tarjeta_recibida` drops and no `resultado_stb` is produced.
- States: IDLE → TARJETA → DIGITO ⇄ GAP → ESPERA_PIN → MONTO → ESPERA_RESP → FIN → IDLE.
- IDLE: when `inicio`=1, latch `pin_cliente`, `tipo_cliente` and `monto_cliente`, clear `aviso`, and go to TARJETA.
- TARJETA: `tarjeta_recibida`=1 is held until the FIN cycle inclusive. Lasts one cycle.
- DIGITO: drive one digit with `digito_stb`=1 for one cycle. A 2-bit index counts digits 0..3. After digits 0–2, go to GAP for `GAP_CYCLES` cycles (skipped if 0). After digit 3, go to ESPERA_PIN.
- ESPERA_PIN: `PIN_WAIT` cycles.
  - `bloqueo` → FIN with BLOQUEO.
  - `pin_incorrecto` → FIN with PIN_INC.
  - If neither arrives, go to MONTO.
- MONTO: `monto_stb`=1 for one cycle; `tipo_trans` and `monto` are driven from the latched values.
- ESPERA_RESP: a down-counter is loaded with `TIMEOUT`.
  - `bloqueo` → BLOQUEO.
  - `fondos_insuficientes` → FONDOS_INSUF.
  - `balance_stb` → OK.
  - Counter reaching 0 → TIMEOUT.
  - `entregar_dinero` is informational only.
- Priority when status inputs coincide: `bloqueo` > `fondos_insuficientes` > `pin_incorrecto` > `balance_stb` > timeout. A response arriving in the same cycle the counter expires wins over timeout.
- FIN: `resultado` is updated, `resultado_stb`=1, `tarjeta_recibida`=1 for this last cycle, then the FSM returns to IDLE.
- `advertencia` is ORed into `aviso` in every non-IDLE state.

## Timing
Cycle n is the edge at which `inicio` is sampled.
- n+1: TARJETA.
- Digit strobes at n+2+k·(`GAP_CYCLES`+1), k=0..3. With the default of 2: n+2, n+5, n+8, n+11.
- ESPERA_PIN covers the `PIN_WAIT` cycles after the last strobe (defaults: n+12..n+15). `monto_stb` follows at n+16.
- A status input sampled at cycle m gives `resultado_stb` at m+1.
- Timeout with no response: `resultado_stb` at `monto_stb` cycle + `TIMEOUT` + 1.
- `ocupado`=1 from n+1 through the FIN cycle. A new `inicio` is accepted in the first IDLE cycle after FIN.
- Inputs are sampled only at `inicio` acceptance; changes mid-session are ignored (except under the macro below).

## Configuration
- `REINTENTO_PIN_EN` defined:
  - `pin_incorrecto` without `bloqueo` in ESPERA_PIN triggers a retry: the FSM re-samples `pin_cliente`, waits `GAP_CYCLES`, and resends all 4 digits.
  - At most 2 retries are made, tracked by a 2-bit counter that is cleared on `inicio`.
  - A third rejection, or any `bloqueo`, ends the session with PIN_INC or BLOQUEO respectively.
- `REINTENTO_PIN_EN` undefined: the first `pin_incorrecto` ends the session with PIN_INC. The retry counter is not built.

## Test plan
- Happy withdrawal: PIN 16'h1234, `tipo_cliente`=1, `monto_cliente`=500, defaults → strobes 1,2,3,4 at n+2/5/8/11; `monto_stb` at n+16; `balance_stb` at n+20 → `resultado`=0, `resultado_stb` at n+21, `tarjeta_recibida` low at n+22.
- Wrong PIN, macro off: `pin_incorrecto` at n+13 → `resultado`=2 at n+14; `monto_stb` never asserts.
- Insufficient funds and simultaneity: `fondos_insuficientes` and `balance_stb` in the same cycle → `resultado`=1.
- Timeout with `TIMEOUT`=10 and no response → `resultado`=4 exactly 11 cycles after `monto_stb`.
- Reset mid-session: `reset`=0 at n+6 → all outputs 0 at n+7; no `resultado_stb`; the next `inicio` restarts at digit 0.
- Retry, macro on: `pin_incorrecto` at n+13 after a change to `pin_cliente`=16'h5678 → digits 5,6,7,8 are resent. Three rejections → `resultado`=2. `bloqueo` together with `pin_incorrecto` → `resultado`=3.

Source files
------------

// File: rtl/sesion_cliente.sv
// sesion_cliente -- customer-side session driver for the cajero_atm keypad protocol.
//
// A start pulse inserts the card. The block then serializes a 4-digit BCD PIN
// as digito/digito_stb pulses, most significant digit first. It issues the
// transaction with monto_stb, watches the ATM status lines and reports one
// coded result through resultado/resultado_stb.
//
// Optional feature: define REINTENTO_PIN_EN to enable PIN retries. With it
// defined, a PIN rejection re-samples pin_cliente and resends all four digits,
// up to 2 retries per session.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   inicio                start pulse, ignored while ocupado
//   pin_cliente[15:0]     four BCD digits, [15:12] sent first
//   tipo_cliente          1 = withdrawal, 0 = deposit
//   monto_cliente[31:0]   transaction amount
//   balance_stb .. bloqueo  ATM status inputs
//   tarjeta_recibida      card-present level (TARJETA through FIN)
//   digito[3:0], digito_stb  PIN digit and its one-cycle strobe
//   tipo_trans, monto[31:0], monto_stb  transaction fields and strobe
//   ocupado               session in progress
//   resultado[2:0]        0 OK, 1 FONDOS_INSUF, 2 PIN_INC, 3 BLOQUEO, 4 TIMEOUT
//   resultado_stb         one-cycle result-valid pulse
//   aviso                 advertencia seen during the current session
module sesion_cliente #(
  parameter int GAP_CYCLES = 2,
  parameter int PIN_WAIT   = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inicio,
  input  logic [15:0] pin_cliente,
  input  logic        tipo_cliente,
  input  logic [31:0] monto_cliente,
  input  logic        balance_stb,
  input  logic        entregar_dinero,
  input  logic        fondos_insuficientes,
  input  logic        pin_incorrecto,
  input  logic        advertencia,
  input  logic        bloqueo,
  output logic        tarjeta_recibida,
  output logic [3:0]  digito,
  output logic        digito_stb,
  output logic        tipo_trans,
  output logic [31:0] monto,
  output logic        monto_stb,
  output logic        ocupado,
  output logic [2:0]  resultado,
  output logic        resultado_stb,
  output logic        aviso
);

  typedef enum logic [2:0] {
    IDLE, TARJETA, DIGITO, GAP, ESPERA_PIN, MONTO, ESPERA_RESP, FIN
  } state_t;

  localparam logic [2:0] RES_OK      = 3'd0;
  localparam logic [2:0] RES_FONDOS  = 3'd1;
  localparam logic [2:0] RES_PIN     = 3'd2;
  localparam logic [2:0] RES_BLOQUEO = 3'd3;
  localparam logic [2:0] RES_TIMEOUT = 3'd4;

  state_t      state, state_next;
  logic [31:0] cnt;        // shared down-counter for GAP, ESPERA_PIN and ESPERA_RESP
  logic [1:0]  idx;        // digit index 0..3
  logic [2:0]  res_reg, res_next;
  logic        aviso_reg;
  logic [15:0] pin_lat;
  logic        tipo_lat;
  logic [31:0] monto_lat;

`ifdef REINTENTO_PIN_EN
  logic [1:0]  reintentos;
  logic        reintentar;
`endif

  // entregar_dinero is informational only and does not affect the session
  logic unused;
  assign unused = entregar_dinero;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; status priority is encoded by the if/else order
  always_comb begin
    state_next = state;
    res_next   = res_reg;
`ifdef REINTENTO_PIN_EN
    reintentar = 1'b0;
`endif
    case (state)
      IDLE:    if (inicio) state_next = TARJETA;
      TARJETA: state_next = DIGITO;
      DIGITO: begin
        if (idx == 2'd3)          state_next = ESPERA_PIN;
        else if (GAP_CYCLES == 0) state_next = DIGITO;
        else                      state_next = GAP;
      end
      GAP: if (cnt <= 32'd1) state_next = DIGITO;
      ESPERA_PIN: begin
        if (bloqueo) begin
          state_next = FIN;
          res_next   = RES_BLOQUEO;
        end else if (pin_incorrecto) begin
`ifdef REINTENTO_PIN_EN
          if (reintentos != 2'd2) begin
            reintentar = 1'b1;
            state_next = (GAP_CYCLES == 0) ? DIGITO : GAP;
          end else begin
            state_next = FIN;
            res_next   = RES_PIN;
          end
`else
          state_next = FIN;
          res_next   = RES_PIN;
`endif
        end else if (cnt <= 32'd1) begin
          state_next = MONTO;
        end
      end
      MONTO: state_next = ESPERA_RESP;
      ESPERA_RESP: begin
        state_next = FIN;
        if (bloqueo)                   res_next = RES_BLOQUEO;
        else if (fondos_insuficientes) res_next = RES_FONDOS;
        else if (pin_incorrecto)       res_next = RES_PIN;
        else if (balance_stb)          res_next = RES_OK;
        else if (cnt <= 32'd1)         res_next = RES_TIMEOUT;
        else                           state_next = ESPERA_RESP;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Session control registers: counter, digit index, result, warning flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt        <= '0;
      idx        <= '0;
      res_reg    <= RES_OK;
      aviso_reg  <= 1'b0;
`ifdef REINTENTO_PIN_EN
      reintentos <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (inicio) begin
            idx        <= '0;
            aviso_reg  <= 1'b0;
`ifdef REINTENTO_PIN_EN
            reintentos <= '0;
`endif
          end
        end
        DIGITO: begin
          if (idx == 2'd3) begin
            cnt <= 32'(PIN_WAIT);
          end else begin
            idx <= idx + 2'd1;
            cnt <= 32'(GAP_CYCLES);
          end
        end
        GAP: cnt <= cnt - 32'd1;
        ESPERA_PIN: begin
          cnt <= cnt - 32'd1;
`ifdef REINTENTO_PIN_EN
          if (reintentar) begin
            idx        <= '0;
            cnt        <= 32'(GAP_CYCLES);
            reintentos <= reintentos + 2'd1;
          end
`endif
        end
        MONTO:       cnt <= 32'(TIMEOUT);
        ESPERA_RESP: cnt <= cnt - 32'd1;
        default:     cnt <= cnt;
      endcase
      if (state != IDLE && advertencia) aviso_reg <= 1'b1;
      if (state_next == FIN)            res_reg   <= res_next;
    end
  end

  // Transaction data latches; outputs are gated by state so these need no reset
  always_ff @(posedge clk) begin
    if (state == IDLE && inicio) begin
      pin_lat   <= pin_cliente;
      tipo_lat  <= tipo_cliente;
      monto_lat <= monto_cliente;
    end
`ifdef REINTENTO_PIN_EN
    else if (reintentar) begin
      pin_lat <= pin_cliente;
    end
`endif
  end

  // Output logic (Moore)
  always_comb begin
    tarjeta_recibida = (state != IDLE);
    ocupado          = (state != IDLE);
    digito_stb       = (state == DIGITO);
    digito           = '0;
    if (state == DIGITO) begin
      case (idx)
        2'd0:    digito = pin_lat[15:12];
        2'd1:    digito = pin_lat[11:8];
        2'd2:    digito = pin_lat[7:4];
        default: digito = pin_lat[3:0];
      endcase
    end
    monto_stb  = (state == MONTO);
    tipo_trans = 1'b0;
    monto      = '0;
    if (state == MONTO || state == ESPERA_RESP || state == FIN) begin
      tipo_trans = tipo_lat;
      monto      = monto_lat;
    end
    resultado     = res_reg;
    resultado_stb = (state == FIN);
    aviso         = aviso_reg;
  end

endmodule

// File: tb/tb_sesion_cliente.sv
// Testbench for sesion_cliente: scoreboard of expected digit, amount and
// result strobes (value and cycle), checked by a negedge monitor.
module tb_sesion_cliente;

  localparam int G  = 2;
  localparam int PW = 4;
  localparam int TO = 10;

  localparam logic [5:0] S_BAL = 6'b000001;
  localparam logic [5:0] S_ENT = 6'b000010;
  localparam logic [5:0] S_FON = 6'b000100;
  localparam logic [5:0] S_PIN = 6'b001000;
  localparam logic [5:0] S_ADV = 6'b010000;
  localparam logic [5:0] S_BLQ = 6'b100000;

  logic        clk = 1'b0;
  logic        reset;
  logic        inicio;
  logic [15:0] pin_cliente;
  logic        tipo_cliente;
  logic [31:0] monto_cliente;
  logic [5:0]  st;
  logic        tarjeta_recibida;
  logic [3:0]  digito;
  logic        digito_stb;
  logic        tipo_trans;
  logic [31:0] monto;
  logic        monto_stb;
  logic        ocupado;
  logic [2:0]  resultado;
  logic        resultado_stb;
  logic        aviso;

  sesion_cliente #(.GAP_CYCLES(G), .PIN_WAIT(PW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .inicio(inicio), .pin_cliente(pin_cliente),
    .tipo_cliente(tipo_cliente), .monto_cliente(monto_cliente),
    .balance_stb(st[0]), .entregar_dinero(st[1]), .fondos_insuficientes(st[2]),
    .pin_incorrecto(st[3]), .advertencia(st[4]), .bloqueo(st[5]),
    .tarjeta_recibida(tarjeta_recibida), .digito(digito), .digito_stb(digito_stb),
    .tipo_trans(tipo_trans), .monto(monto), .monto_stb(monto_stb),
    .ocupado(ocupado), .resultado(resultado), .resultado_stb(resultado_stb),
    .aviso(aviso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] v;
    logic        t;
    int          at;
  } exp_t;

  exp_t q_dig[$];
  exp_t q_monto[$];
  exp_t q_res[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic push_digits(input int first_at, input logic [15:0] p);
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e.v  = 32'((p >> (12 - 4 * k)) & 16'hF);
      e.t  = 1'b0;
      e.at = first_at + k * (G + 1);
      q_dig.push_back(e);
    end
  endtask

  task automatic push_monto(input int at, input logic t, input logic [31:0] m);
    exp_t e;
    e.v = m; e.t = t; e.at = at;
    q_monto.push_back(e);
  endtask

  task automatic push_res(input int at, input logic [2:0] r);
    exp_t e;
    e.v = 32'(r); e.t = 1'b0; e.at = at;
    q_res.push_back(e);
  endtask

  // Monitor: at a negedge after edge cyc, outputs are those sampled at edge cyc+1
  always @(negedge clk) begin
    int now;
    exp_t e;
    now = cyc + 1;
    if (digito_stb) begin
      if (q_dig.size() == 0) chk("dig_extra", 32'(q_dig.size()), 1);
      else begin
        e = q_dig.pop_front();
        chk("dig_val", 32'(digito), e.v);
        chk("dig_at", 32'(now), 32'(e.at));
      end
    end
    if (monto_stb) begin
      if (q_monto.size() == 0) chk("monto_extra", 32'(q_monto.size()), 1);
      else begin
        e = q_monto.pop_front();
        chk("monto_val", monto, e.v);
        chk("tipo_val", 32'(tipo_trans), 32'(e.t));
        chk("monto_at", 32'(now), 32'(e.at));
      end
    end
    if (resultado_stb) begin
      if (q_res.size() == 0) chk("res_extra", 32'(q_res.size()), 1);
      else begin
        e = q_res.pop_front();
        chk("res_val", 32'(resultado), e.v);
        chk("res_at", 32'(now), 32'(e.at));
      end
    end
  end

  // Present inputs so that inicio is sampled at edge n
  task automatic start(input logic [15:0] p, input logic t, input logic [31:0] m, output int n);
    pin_cliente   = p;
    tipo_cliente  = t;
    monto_cliente = m;
    inicio        = 1'b1;
    n             = cyc + 1;
    @(negedge clk);
    inicio = 1'b0;
  endtask

  task automatic at_edge(input int m);
    while (cyc + 1 < m) @(negedge clk);
  endtask

  task automatic pulse(input int m, input logic [5:0] mask);
    at_edge(m);
    st = mask;
    @(negedge clk);
    st = '0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (ocupado && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("idle_bound", 32'(ocupado), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b0; inicio = 1'b0; st = '0;
    pin_cliente = '0; tipo_cliente = 1'b0; monto_cliente = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {tarjeta_recibida, digito, digito_stb, tipo_trans, monto_stb,
                    ocupado, resultado, resultado_stb, aviso}, 0);
    chk("rst_monto", monto, 0);
    reset = 1'b1;
    @(negedge clk);

    // Happy withdrawal; mid-session input changes must be ignored
    start(16'h1234, 1'b1, 32'd500, n);
    push_digits(n + 2, 16'h1234);
    push_monto(n + 16, 1'b1, 32'd500);
    push_res(n + 21, 3'd0);
    chk("busy", 32'(ocupado), 1);
    chk("card_on", 32'(tarjeta_recibida), 1);
    pin_cliente = 16'hFFFF; monto_cliente = '0; tipo_cliente = 1'b0;
    pulse(n + 18, S_ADV);
    chk("aviso_set", 32'(aviso), 1);
    pulse(n + 20, S_BAL);
    @(negedge clk);
    chk("card_drop", 32'(tarjeta_recibida), 0);
    wait_idle();

    // Wrong PIN
`ifndef REINTENTO_PIN_EN
    start(16'h0987, 1'b1, 32'd100, n);
    chk("aviso_clr", 32'(aviso), 0);
    push_digits(n + 2, 16'h0987);
    push_res(n + 14, 3'd2);
    pulse(n + 13, S_PIN);
    wait_idle();
`else
    start(16'h0987, 1'b1, 32'd100, n);
    chk("aviso_clr", 32'(aviso), 0);
    push_digits(n + 2, 16'h0987);
    at_edge(n + 13);
    pin_cliente = 16'h5678;
    pulse(n + 13, S_PIN);
    push_digits(n + 16, 16'h5678);
    at_edge(n + 27);
    pin_cliente = 16'h4321;
    pulse(n + 27, S_PIN);
    push_digits(n + 30, 16'h4321);
    push_res(n + 42, 3'd2);
    pulse(n + 41, S_PIN);
    wait_idle();
`endif

    // bloqueo together with pin_incorrecto
    start(16'h3141, 1'b0, 32'd1, n);
    push_digits(n + 2, 16'h3141);
    push_res(n + 14, 3'd3);
    pulse(n + 13, S_BLQ | S_PIN);
    wait_idle();

    // Insufficient funds coinciding with balance_stb
    start(16'h4455, 1'b0, 32'hDEADBEEF, n);
    push_digits(n + 2, 16'h4455);
    push_monto(n + 16, 1'b0, 32'hDEADBEEF);
    push_res(n + 19, 3'd1);
    pulse(n + 18, S_FON | S_BAL);
    wait_idle();

    // Timeout with no response
    start(16'h1111, 1'b1, 32'd42, n);
    push_digits(n + 2, 16'h1111);
    push_monto(n + 16, 1'b1, 32'd42);
    push_res(n + 16 + TO + 1, 3'd4);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("res_hold", 32'(resultado), 4);

    // Reset mid-session aborts without a result
    start(16'h7777, 1'b1, 32'd9, n);
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      e.v = 32'h7; e.t = 1'b0; e.at = n + 2 + k * (G + 1);
      q_dig.push_back(e);
    end
    pulse(n + 3, S_ADV);
    at_edge(n + 6);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_ctl", {tarjeta_recibida, digito, digito_stb, tipo_trans, monto_stb,
                        ocupado, resultado, resultado_stb, aviso}, 0);
    chk("rst_mid_monto", monto, 0);
    reset = 1'b1;
    @(negedge clk);

    // Restart after reset begins at digit 0; bloqueo beats fondos in ESPERA_RESP
    start(16'h2580, 1'b0, 32'd3, n);
    push_digits(n + 2, 16'h2580);
    push_monto(n + 16, 1'b0, 32'd3);
    push_res(n + 20, 3'd3);
    pulse(n + 18, S_ENT);
    pulse(n + 19, S_BLQ | S_FON);
    wait_idle();

    repeat (5) @(negedge clk);
    chk("q_dig_left", 32'(q_dig.size()), 0);
    chk("q_monto_left", 32'(q_monto.size()), 0);
    chk("q_res_left", 32'(q_res.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
